// File: rtl/addsub_shared_scheduler.sv
// addsub_shared_scheduler
// Shares one no-carry adder/subtractor (+/-A +/-B mod 2^WORD_WIDTH) among
// REQUESTERS clients through a round-robin arbiter and a 2-stage pipeline
// (S1 = operands, S2 = sum). Each result carries its requester index.
//
// Ports:
//   clock, reset_n                      clock, async active-low reset
//   req_valid/req_ready   [REQUESTERS]  per-client handshake (ready is combinational)
//   req_A/req_B           [R*W]         client i operands at [i*W +: W]
//   req_A_negative/_B_negative [R]      negate flags
//   result, result_id, result_valid     registered result, tag and valid
//   result_ready                        downstream accept
//   result_overflow                     only when ADDSUB_SCHED_OVERFLOW_EN is defined
//
// Optional feature macro: ADDSUB_SCHED_OVERFLOW_EN (signed overflow flag).
module addsub_shared_scheduler #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [REQUESTERS-1:0]            req_valid,
  output logic [REQUESTERS-1:0]            req_ready,
  input  logic [REQUESTERS*WORD_WIDTH-1:0] req_A,
  input  logic [REQUESTERS-1:0]            req_A_negative,
  input  logic [REQUESTERS*WORD_WIDTH-1:0] req_B,
  input  logic [REQUESTERS-1:0]            req_B_negative,
  output logic [WORD_WIDTH-1:0]            result,
  output logic [ID_WIDTH-1:0]              result_id,
  output logic                             result_valid,
  input  logic                             result_ready
`ifdef ADDSUB_SCHED_OVERFLOW_EN
  ,
  output logic                             result_overflow
`endif
);

  localparam int unsigned W = WORD_WIDTH;

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [REQUESTERS-1:0] masked;
  logic [REQUESTERS-1:0] pick;
  logic [REQUESTERS-1:0] grant;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  found;
  logic [W-1:0]          sel_a;
  logic [W-1:0]          sel_b;
  logic                  sel_an;
  logic                  sel_bn;

  logic                  s1_valid;
  logic [W-1:0]          s1_a;
  logic [W-1:0]          s1_b;
  logic                  s1_an;
  logic                  s1_bn;
  logic [ID_WIDTH-1:0]   s1_id;

  logic                  adv1;
  logic                  adv2;
  logic                  transfer;
  logic [W-1:0]          sum;

  // Round-robin pick: prefer requesters at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    masked   = req_valid;
    pick     = '0;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    sel_an   = 1'b0;
    sel_bn   = 1'b0;
    for (int unsigned j = 0; j < REQUESTERS; j++) begin
      if (j < 32'(rr_ptr)) masked[j] = 1'b0;
    end
    pick = (masked != '0) ? masked : req_valid;
    for (int unsigned j = 0; j < REQUESTERS; j++) begin
      if (!found && pick[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grant_id = ID_WIDTH'(j);
        sel_a    = req_A[j*W +: W];
        sel_b    = req_B[j*W +: W];
        sel_an   = req_A_negative[j];
        sel_bn   = req_B_negative[j];
      end
    end
  end

  // Pipeline enables; ready is forced low while reset is asserted.
  assign adv2      = !result_valid || result_ready;
  assign adv1      = !s1_valid || adv2;
  assign req_ready = reset_n ? (grant & {REQUESTERS{adv1}}) : '0;
  assign transfer  = |req_ready;

  // Conditional negation folded into the add as invert-plus-one.
  assign sum = (s1_a ^ {W{s1_an}}) + (s1_b ^ {W{s1_bn}}) + W'(s1_an) + W'(s1_bn);

`ifdef ADDSUB_SCHED_OVERFLOW_EN
  logic [W+1:0] a_ext;
  logic [W+1:0] b_ext;
  logic [W+1:0] exact;
  logic         ovf;

  // Exact signed sum in W+2 bits; overflow when the top three bits disagree.
  always_comb begin
    a_ext = {{2{s1_a[W-1]}}, s1_a};
    b_ext = {{2{s1_b[W-1]}}, s1_b};
    if (s1_an) a_ext = -a_ext;
    if (s1_bn) b_ext = -b_ext;
    exact = a_ext + b_ext;
    ovf   = !((exact[W+1:W-1] == 3'b000) || (exact[W+1:W-1] == 3'b111));
  end
`endif

  // Arbiter pointer advances past the client just accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (32'(grant_id) == REQUESTERS - 1) ? '0 : grant_id + ID_WIDTH'(1);
    end
  end

  // S1: operand capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_an    <= 1'b0;
      s1_bn    <= 1'b0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_an <= sel_an;
        s1_bn <= sel_bn;
        s1_id <= grant_id;
      end
    end
  end

  // S2: result register, held while downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
      result_overflow <= 1'b0;
`endif
    end else if (adv2) begin
      result       <= sum;
      result_id    <= s1_id;
      result_valid <= s1_valid;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
      result_overflow <= ovf;
`endif
    end
  end

endmodule

// File: tb/tb_addsub_shared_scheduler.sv
// Directed self-checking bench for addsub_shared_scheduler (default parameters).
module tb_addsub_shared_scheduler;

  localparam int unsigned W = 36;
  localparam int unsigned R = 4;
  localparam int unsigned IDW = 2;

  logic           clock;
  logic           reset_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*W-1:0] req_A;
  logic [R-1:0]   req_A_negative;
  logic [R*W-1:0] req_B;
  logic [R-1:0]   req_B_negative;
  logic [W-1:0]   result;
  logic [IDW-1:0] result_id;
  logic           result_valid;
  logic           result_ready;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
  logic           result_overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  addsub_shared_scheduler #(
    .WORD_WIDTH(W),
    .REQUESTERS(R),
    .ID_WIDTH  (IDW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_A          (req_A),
    .req_A_negative (req_A_negative),
    .req_B          (req_B),
    .req_B_negative (req_B_negative),
    .result         (result),
    .result_id      (result_id),
    .result_valid   (result_valid),
    .result_ready   (result_ready)
`ifdef ADDSUB_SCHED_OVERFLOW_EN
    ,
    .result_overflow(result_overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int c, input logic [W-1:0] a, input logic an,
                        input logic [W-1:0] b, input logic bn);
    req_A[c*W +: W]   = a;
    req_A_negative[c] = an;
    req_B[c*W +: W]   = b;
    req_B_negative[c] = bn;
  endtask

  // One isolated op from client c; checks grant, 2-cycle latency, value and tag.
  task automatic single_op(input string tag, input int c, input logic [W-1:0] a, input logic an,
                           input logic [W-1:0] b, input logic bn,
                           input logic [W-1:0] exp, input logic exp_ov);
    logic [R-1:0] e;
    e = R'(1) << c;
    set_op(c, a, an, b, bn);
    req_valid = e;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(e));
    tick();
    req_valid = '0;
    check({tag, "_lat1_valid"}, 64'(result_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(result_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(exp));
    check({tag, "_id"}, 64'(result_id), 64'(c));
`ifdef ADDSUB_SCHED_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(result_overflow), 64'(exp_ov));
`else
    if (exp_ov) begin end
`endif
    tick();
    check({tag, "_drained"}, 64'(result_valid), 64'd0);
  endtask

  // Expected results for the shared operand set: A=i*1000+7, B=-i.
  logic [W-1:0] exp_rr [R];
  logic [R-1:0] bp_rdy [5];
  int           acc;

  initial begin
    exp_rr[0] = 36'd7;
    exp_rr[1] = 36'd1006;
    exp_rr[2] = 36'd2005;
    exp_rr[3] = 36'd3004;
    bp_rdy[0] = 4'b0001;
    bp_rdy[1] = 4'b0010;
    bp_rdy[2] = 4'b0000;
    bp_rdy[3] = 4'b0000;
    bp_rdy[4] = 4'b0000;

    reset_n        = 1'b0;
    req_valid      = '1;
    req_A          = '0;
    req_B          = '0;
    req_A_negative = '0;
    req_B_negative = '0;
    result_ready   = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_id", 64'(result_id), 64'd0);
`ifdef ADDSUB_SCHED_OVERFLOW_EN
    check("rst_ovf", 64'(result_overflow), 64'd0);
`endif
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    // Isolated ops; pointer ends at 1, 3, 0, 2 respectively.
    single_op("sub", 0, 36'd5, 1'b0, 36'd3, 1'b1, 36'd2, 1'b0);
    single_op("negmin", 2, 36'h8_0000_0000, 1'b1, 36'd0, 1'b0, 36'h8_0000_0000, 1'b1);
    single_op("cancel", 3, 36'd7, 1'b0, 36'hF_FFFF_FFF9, 1'b0, 36'd0, 1'b0);
    single_op("nega", 1, 36'd100, 1'b1, 36'd40, 1'b0, 36'hF_FFFF_FFC4, 1'b0);

    // Clients 1 and 3 with rr_ptr=2: client 3 first, then client 1.
    set_op(3, 36'd50, 1'b0, 36'd8, 1'b0);
    set_op(1, 36'd9, 1'b1, 36'd4, 1'b0);
    req_valid = 4'b1010;
    #1;
    check("rr13_first", 64'(req_ready), 64'b1000);
    tick();
    check("rr13_second", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    check("rr13_v1", 64'(result_valid), 64'd1);
    check("rr13_id1", 64'(result_id), 64'd3);
    check("rr13_res1", 64'(result), 64'd58);
    tick();
    check("rr13_id2", 64'(result_id), 64'd1);
    check("rr13_res2", 64'(result), 64'(36'hF_FFFF_FFFB));
    tick();
    check("rr13_drained", 64'(result_valid), 64'd0);

    // Fill S1 and S2 under backpressure, then reset mid-stream.
    for (int i = 0; i < int'(R); i++) set_op(i, W'(i * 1000 + 7), 1'b0, W'(i), 1'b1);
    result_ready = 1'b0;
    req_valid    = '1;
    tick();
    tick();
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_valid", 64'(result_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    reset_n      = 1'b1;
    result_ready = 1'b1;
    #1;
    check("midrst_ptr0", 64'(req_ready), 64'b0001);
    check("midrst_noresult", 64'(result_valid), 64'd0);

    // All four clients continuously valid: ids 0,1,2,3,0,... one per cycle.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(R'(1) << (k % 4)));
      tick();
      if (k >= 1) begin
        check($sformatf("rr_valid%0d", k), 64'(result_valid), 64'd1);
        check($sformatf("rr_id%0d", k), 64'(result_id), 64'((k - 1) % 4));
        check($sformatf("rr_res%0d", k), 64'(result), 64'(exp_rr[(k - 1) % 4]));
      end
    end
    req_valid = '0;
    tick();
    check("rr_last_id", 64'(result_id), 64'd3);
    check("rr_last_res", 64'(result), 64'(exp_rr[3]));
    tick();
    check("rr_drained", 64'(result_valid), 64'd0);

    // result_ready low for 5 cycles: exactly two accepts, held result stable.
    result_ready = 1'b0;
    req_valid    = '1;
    acc          = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready != '0) acc++;
      check($sformatf("bp_ready%0d", k), 64'(req_ready), 64'(bp_rdy[k]));
      tick();
      if (k >= 1) begin
        check($sformatf("bp_hold_v%0d", k), 64'(result_valid), 64'd1);
        check($sformatf("bp_hold_id%0d", k), 64'(result_id), 64'd0);
        check($sformatf("bp_hold_res%0d", k), 64'(result), 64'(exp_rr[0]));
      end
    end
    check("bp_accepts", 64'(acc), 64'd2);
    req_valid    = '0;
    result_ready = 1'b1;
    tick();
    check("bp_rel_valid", 64'(result_valid), 64'd1);
    check("bp_rel_id", 64'(result_id), 64'd1);
    check("bp_rel_res", 64'(result), 64'(exp_rr[1]));
    tick();
    check("bp_rel_drained", 64'(result_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
